// File: rtl/console_rx_if.sv
// Console receiver signal bundle: serial line and clear pulse in, character and status flags out.
interface console_rx_if;
  logic       console_rxd;
  logic       kbd_clear;
  logic [7:0] rx_data;
  logic       kbd_flag;
  logic       overrun;
  logic       framing_error;

  modport master (
    output console_rxd,
    output kbd_clear,
    input  rx_data,
    input  kbd_flag,
    input  overrun,
    input  framing_error
  );

  modport slave (
    input  console_rxd,
    input  kbd_clear,
    output rx_data,
    output kbd_flag,
    output overrun,
    output framing_error
  );
endinterface

// File: rtl/console_rx.sv
// 8N1 console receiver: synchronised line, centre-sampled bits, keyboard flag/overrun/framing status.
// Flag rises 3 clocks after the stop-bit centre; no backpressure, newest character overwrites rx_data.
module console_rx #(
  parameter int unsigned BIT_TICKS = 434
) (
  input  logic         clock,
  input  logic         reset,
  console_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI
  } state_t;

  localparam logic [15:0] HALF_LOAD = 16'(BIT_TICKS / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(BIT_TICKS - 1);

  state_t      state;
  state_t      state_nxt;
  logic        sync1;
  logic        rxs;
  logic [15:0] tick;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_data_q;
  logic        kbd_flag_q;
  logic        overrun_q;
  logic        framing_error_q;

  logic        sample;
  logic        load_half;
  logic        running;
  logic        clr_bits;
  logic        shift_en;
  logic        deliver;

  assign sample = (tick == 16'd0);

  // Both flops idle high so reset never manufactures a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.console_rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    running   = 1'b0;
    clr_bits  = 1'b0;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          load_half = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        running = 1'b1;
        if (sample) begin
          if (rxs) begin
            state_nxt = IDLE;
          end else begin
            clr_bits  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        running = 1'b1;
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        running = 1'b1;
        if (sample) begin
          deliver   = 1'b1;
          state_nxt = rxs ? IDLE : WAITHI;
        end
      end
      WAITHI: begin
        if (rxs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Leaving to IDLE parks the counter at 0 so the next start edge always loads half a bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick <= 16'd0;
    end else if (load_half) begin
      tick <= HALF_LOAD;
    end else if (running) begin
      if (sample) begin
        tick <= (state_nxt == IDLE) ? 16'd0 : FULL_LOAD;
      end else begin
        tick <= tick - 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (clr_bits) begin
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= {rxs, shreg[7:1]};
    end
  end

  // A delivery outranks a simultaneous clear; the clear only suppresses the overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data_q       <= 8'h00;
      kbd_flag_q      <= 1'b0;
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;
    end else if (deliver) begin
      rx_data_q       <= shreg;
      kbd_flag_q      <= 1'b1;
      overrun_q       <= !bus.kbd_clear && (overrun_q || kbd_flag_q);
      framing_error_q <= !rxs;
    end else if (bus.kbd_clear) begin
      kbd_flag_q      <= 1'b0;
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.kbd_flag      = kbd_flag_q;
  assign bus.overrun       = overrun_q;
  assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_console_rx.sv
// Bench for console_rx at 16 clocks per bit: scoreboarded deliveries plus per-scenario flag checks.
module tb_console_rx;

  localparam int BT = 16;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       ov;
    int         centre;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   deliveries = 0;
  exp_t sb[$];
  exp_t m;
  logic [7:0] p_data;
  logic       p_flag, p_ov, p_fe;

  console_rx_if bus();

  console_rx #(.BIT_TICKS(BT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Delivery monitor: any fresh character presentation pops the scoreboard.
  always @(negedge clock) begin
    if (!reset && bus.kbd_flag === 1'b1 &&
        (p_flag !== 1'b1 || bus.rx_data !== p_data || bus.framing_error !== p_fe ||
         (bus.overrun === 1'b1 && p_ov !== 1'b1))) begin
      deliveries = deliveries + 1;
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_delivery: got rx_data=%h with no character outstanding", bus.rx_data);
      end else begin
        m = sb.pop_front();
        checks = checks + 4;
        if (bus.rx_data !== m.data) begin
          errors = errors + 1;
          $display("FAIL sb_data: got %h want %h", bus.rx_data, m.data);
        end
        if (bus.framing_error !== m.fe) begin
          errors = errors + 1;
          $display("FAIL sb_framing_error: got %b want %b (data %h)", bus.framing_error, m.fe, m.data);
        end
        if (bus.overrun !== m.ov) begin
          errors = errors + 1;
          $display("FAIL sb_overrun: got %b want %b (data %h)", bus.overrun, m.ov, m.data);
        end
        if (cyc - m.centre > 3 || cyc - m.centre < 1) begin
          errors = errors + 1;
          $display("FAIL sb_latency: got %0d clocks want 1..3 (data %h)", cyc - m.centre, m.data);
        end
      end
    end
    p_data <= bus.rx_data;
    p_flag <= bus.kbd_flag;
    p_ov   <= bus.overrun;
    p_fe   <= bus.framing_error;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send_char(input logic [7:0] d, input logic stop, input logic exp_ov,
                           input logic clr_on_delivery);
    exp_t e;
    logic [9:0] fr;
    e.data   = d;
    e.fe     = !stop;
    e.ov     = exp_ov;
    e.centre = cyc + 9 * BT + BT / 2;
    sb.push_back(e);
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      bus.console_rxd = fr[b];
      for (int j = 0; j < BT; j++) begin
        if (clr_on_delivery && b == 9) bus.kbd_clear = (j == 10);
        @(negedge clock);
      end
    end
    bus.kbd_clear = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.kbd_clear = 1'b1;
    @(negedge clock);
    bus.kbd_clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    bus.console_rxd = 1'b1;
    bus.kbd_clear   = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks = checks + 4;
    if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    if (bus.kbd_flag !== 1'b0) begin errors++; $display("FAIL reset_kbd_flag: got %b want 0", bus.kbd_flag); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b want 0", bus.framing_error); end
  endtask

  task automatic test_basic();
    send_char(8'hC1, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    checks = checks + 3;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d outstanding want 0", sb.size()); sb.delete(); end
    if (bus.rx_data !== 8'hC1 || bus.kbd_flag !== 1'b1) begin
      errors++; $display("FAIL basic_out: got data=%h flag=%b want C1/1", bus.rx_data, bus.kbd_flag);
    end
    pulse_clear();
    if (bus.rx_data !== 8'hC1 || bus.kbd_flag !== 1'b0 || bus.overrun !== 1'b0 || bus.framing_error !== 1'b0) begin
      errors++; $display("FAIL basic_clear: got data=%h flag=%b ov=%b fe=%b want C1/0/0/0",
                         bus.rx_data, bus.kbd_flag, bus.overrun, bus.framing_error);
    end
  endtask

  task automatic test_glitch();
    int d0;
    d0 = deliveries;
    bus.console_rxd = 1'b0;
    repeat (5) @(negedge clock);
    bus.console_rxd = 1'b1;
    repeat (3 * BT) @(negedge clock);
    checks = checks + 1;
    if (deliveries != d0 || bus.kbd_flag !== 1'b0) begin
      errors++; $display("FAIL glitch_no_delivery: got %0d deliveries flag=%b want 0/0", deliveries - d0, bus.kbd_flag);
    end
    send_char(8'h55, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    checks = checks + 1;
    if (sb.size() != 0 || bus.rx_data !== 8'h55) begin
      errors++; $display("FAIL glitch_next_char: got data=%h pending=%0d want 55/0", bus.rx_data, sb.size());
      sb.delete();
    end
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    send_char(8'h41, 1'b1, 1'b0, 1'b0);
    send_char(8'h42, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    checks = checks + 2;
    if (sb.size() != 0 || bus.rx_data !== 8'h42 || bus.kbd_flag !== 1'b1 || bus.overrun !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun: got data=%h flag=%b ov=%b pending=%0d want 42/1/1/0",
                         bus.rx_data, bus.kbd_flag, bus.overrun, sb.size());
      sb.delete();
    end
    pulse_clear();
    if (bus.rx_data !== 8'h42 || bus.kbd_flag !== 1'b0 || bus.overrun !== 1'b0 || bus.framing_error !== 1'b0) begin
      errors++; $display("FAIL b2b_clear: got data=%h flag=%b ov=%b fe=%b want 42/0/0/0",
                         bus.rx_data, bus.kbd_flag, bus.overrun, bus.framing_error);
    end
  endtask

  task automatic test_break();
    int d0;
    d0 = deliveries;
    send_char(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (40 * BT) @(negedge clock);
    checks = checks + 1;
    if (deliveries != d0 + 1 || bus.rx_data !== 8'h00 || bus.framing_error !== 1'b1) begin
      errors++; $display("FAIL break_single: got %0d deliveries data=%h fe=%b want 1/00/1",
                         deliveries - d0, bus.rx_data, bus.framing_error);
    end
    pulse_clear();
    bus.console_rxd = 1'b1;
    repeat (2 * BT) @(negedge clock);
    send_char(8'h7F, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    checks = checks + 1;
    if (sb.size() != 0 || bus.rx_data !== 8'h7F || bus.framing_error !== 1'b0) begin
      errors++; $display("FAIL break_recover: got data=%h fe=%b pending=%0d want 7F/0/0",
                         bus.rx_data, bus.framing_error, sb.size());
      sb.delete();
    end
    pulse_clear();
  endtask

  task automatic test_clear_on_delivery();
    send_char(8'h21, 1'b1, 1'b0, 1'b0);
    send_char(8'h22, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    checks = checks + 1;
    if (sb.size() != 0 || bus.rx_data !== 8'h22 || bus.kbd_flag !== 1'b1 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL clear_on_delivery: got data=%h flag=%b ov=%b pending=%0d want 22/1/0/0",
                         bus.rx_data, bus.kbd_flag, bus.overrun, sb.size());
      sb.delete();
    end
    pulse_clear();
  endtask

  task automatic test_reset_mid_char();
    logic [9:0] fr;
    int d0;
    d0 = deliveries;
    fr = {1'b1, 8'hAA, 1'b0};
    for (int b = 0; b < 5; b++) begin
      bus.console_rxd = fr[b];
      repeat (BT) @(negedge clock);
    end
    bus.console_rxd = fr[5];
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    bus.console_rxd = 1'b1;
    repeat (3 * BT) @(negedge clock);
    checks = checks + 2;
    if (deliveries != d0 || bus.kbd_flag !== 1'b0) begin
      errors++; $display("FAIL midreset_discard: got %0d deliveries flag=%b want 0/0", deliveries - d0, bus.kbd_flag);
    end
    if (bus.rx_data !== 8'h00 || bus.overrun !== 1'b0 || bus.framing_error !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got data=%h ov=%b fe=%b want 00/0/0",
                         bus.rx_data, bus.overrun, bus.framing_error);
    end
    send_char(8'h33, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    checks = checks + 1;
    if (sb.size() != 0 || bus.rx_data !== 8'h33 || bus.kbd_flag !== 1'b1) begin
      errors++; $display("FAIL midreset_next: got data=%h flag=%b pending=%0d want 33/1/0",
                         bus.rx_data, bus.kbd_flag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bus.console_rxd = 1'b1;
    bus.kbd_clear   = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_break();
    test_clear_on_delivery();
    test_reset_mid_char();
    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
